// File: rtl/opt_cipher_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : opt_cipher_core                                               |
// | Brief    : Iterative XOR/rotate block cipher, one round per clock, with  |
// |            valid/ready streaming, explicit key load and per-word         |
// |            encrypt/decrypt. Define OPT_CIPHER_CHAIN_EN for CBC-style     |
// |            chaining; without it the core runs in ECB mode.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module opt_cipher_core #(
    parameter int DATA_W = 8,
    parameter int KEY_W  = 16,
    parameter int ROUNDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_load,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_decrypt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int c_cnt_w  = $clog2(ROUNDS + 1);
    // Decrypt walks the round keys downward, so its first round key is the
    // key rotated by the last round index.
    localparam int c_dec_sh = (ROUNDS - 1) % KEY_W;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(ROUNDS - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]         r_state;
    logic [KEY_W-1:0]   r_key;
    logic [KEY_W-1:0]   r_rk;
    logic [DATA_W-1:0]  r_s;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_dec;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_valid;
`ifdef OPT_CIPHER_CHAIN_EN
    logic [DATA_W-1:0]  r_chain;
    logic [DATA_W-1:0]  r_din;
`endif

    logic [DATA_W-1:0]  w_rk;
    logic [DATA_W-1:0]  w_enc_x;
    logic [DATA_W-1:0]  w_enc;
    logic [DATA_W-1:0]  w_dec;
    logic [DATA_W-1:0]  w_round;
    logic [KEY_W-1:0]   w_rk_rotl;
    logic [KEY_W-1:0]   w_rk_rotr;
    logic [KEY_W-1:0]   w_key_dec_init;
    logic [DATA_W-1:0]  w_s_init;
    logic [DATA_W-1:0]  w_out_final;

    // The working round key register is rotated one bit per round instead of
    // indexing the key by round number, so no barrel shifter is needed.
    assign w_rk           = r_rk[DATA_W-1:0];
    assign w_rk_rotl      = {r_rk[KEY_W-2:0], r_rk[KEY_W-1]};
    assign w_rk_rotr      = {r_rk[0], r_rk[KEY_W-1:1]};
    assign w_key_dec_init = (r_key << c_dec_sh) | (r_key >> (KEY_W - c_dec_sh));

    assign w_enc_x = r_s ^ w_rk;
    assign w_enc   = {w_enc_x[DATA_W-2:0], w_enc_x[DATA_W-1]};
    assign w_dec   = {r_s[0], r_s[DATA_W-1:1]} ^ w_rk;
    assign w_round = r_dec ? w_dec : w_enc;

`ifdef OPT_CIPHER_CHAIN_EN
    assign w_s_init    = in_decrypt ? in_data : (in_data ^ r_chain);
    assign w_out_final = r_dec ? (w_round ^ r_chain) : w_round;
`else
    assign w_s_init    = in_data;
    assign w_out_final = w_round;
`endif

    assign in_ready  = (r_state == c_idle) & ~key_load;
    assign busy      = (r_state != c_idle);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Control FSM, round datapath and key/chain registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_key       <= '0;
            r_rk        <= '0;
            r_s         <= '0;
            r_cnt       <= '0;
            r_dec       <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
`ifdef OPT_CIPHER_CHAIN_EN
            r_chain     <= '0;
            r_din       <= '0;
`endif
        end else begin
            case (r_state)
                c_idle: begin
                    if (key_load) begin
                        r_key   <= key_in;
`ifdef OPT_CIPHER_CHAIN_EN
                        r_chain <= '0;
`endif
                    end else if (in_valid) begin
                        r_s     <= w_s_init;
                        r_dec   <= in_decrypt;
                        r_rk    <= in_decrypt ? w_key_dec_init : r_key;
                        r_cnt   <= '0;
`ifdef OPT_CIPHER_CHAIN_EN
                        r_din   <= in_data;
`endif
                        r_state <= c_run;
                    end
                end
                c_run: begin
                    r_s  <= w_round;
                    r_rk <= r_dec ? w_rk_rotr : w_rk_rotl;
                    if (r_cnt == c_last) begin
                        // Last round result goes straight to the output so
                        // the result is visible ROUNDS edges after accept.
                        r_out_data  <= w_out_final;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= c_done;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_done: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
`ifdef OPT_CIPHER_CHAIN_EN
                        r_chain     <= r_dec ? r_din : r_out_data;
`endif
                        r_state     <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_opt_cipher_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_opt_cipher_core                                            |
// | Brief    : Self-checking bench for opt_cipher_core: directed cases plus  |
// |            randomized words against a behavioural cipher model, with a   |
// |            scoreboard queue checked by an output monitor.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module tb_opt_cipher_core;

    localparam int DATA_W = 8;
    localparam int KEY_W  = 16;
    localparam int ROUNDS = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              key_load;
    logic [KEY_W-1:0]  key_in;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_decrypt;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;
    logic [15:0] m_key;
`ifdef OPT_CIPHER_CHAIN_EN
    logic [7:0]  m_chain;
    logic [7:0]  y2;
`endif
    bit          force_rdy;
    bit          rdy_val;
    int          lat;
    logic [7:0]  rx;
    logic [7:0]  ry;

    always #5 clk = ~clk;

    opt_cipher_core #(
        .DATA_W(DATA_W),
        .KEY_W (KEY_W),
        .ROUNDS(ROUNDS)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_decrypt(in_decrypt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] rk_of(input logic [15:0] key, input int r);
        logic [15:0] k;
        k = key;
        for (int i = 0; i < r % KEY_W; i++) k = {k[14:0], k[15]};
        return k[7:0];
    endfunction

    function automatic logic [7:0] ref_enc(input logic [7:0] x, input logic [15:0] key);
        logic [7:0] s;
        logic [7:0] t;
        s = x;
        for (int r = 0; r < ROUNDS; r++) begin
            t = s ^ rk_of(key, r);
            s = (t << 1) | (t >> 7);
        end
        return s;
    endfunction

    function automatic logic [7:0] ref_dec(input logic [7:0] x, input logic [15:0] key);
        logic [7:0] s;
        s = x;
        for (int r = ROUNDS - 1; r >= 0; r--) s = ((s >> 1) | (s << 7)) ^ rk_of(key, r);
        return s;
    endfunction

    function automatic logic [7:0] model_step(input logic [7:0] x, input logic dec);
        logic [7:0] y;
`ifdef OPT_CIPHER_CHAIN_EN
        if (dec) begin
            y = ref_dec(x, m_key) ^ m_chain;
            m_chain = x;
        end else begin
            y = ref_enc(x ^ m_chain, m_key);
            m_chain = y;
        end
`else
        y = dec ? ref_dec(x, m_key) : ref_enc(x, m_key);
`endif
        return y;
    endfunction

    task automatic model_clear();
`ifdef OPT_CIPHER_CHAIN_EN
        m_chain = 8'h00;
`endif
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every output handshake pops one expected word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got %02h, required no output", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL out_data: got %02h, required %02h", out_data, mon_exp);
                end
            end
        end
    end

    // Downstream backpressure: forced level or random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = force_rdy ? rdy_val : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- drivers (called at posedge+1) ----------------
    task automatic send(input logic [7:0] x, input logic dec, input logic [7:0] exp, input bit push);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid   = 1'b1;
        in_data    = x;
        in_decrypt = dec;
        if (push) exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_data    = 8'($urandom);
        in_decrypt = 1'($urandom);
    endtask

    task automatic send_model(input logic [7:0] x, input logic dec);
        logic [7:0] e;
        e = model_step(x, dec);
        send(x, dec, e, 1'b1);
    endtask

    task automatic send_exp(input logic [7:0] x, input logic dec, input logic [7:0] e);
        void'(model_step(x, dec));
        send(x, dec, e, 1'b1);
    endtask

    task automatic load_key(input logic [15:0] k);
        int guard;
        guard = 0;
        while (busy && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (busy) begin
            check("load_key_timeout", 32'(busy), 32'd0);
            return;
        end
        key_load = 1'b1;
        key_in   = k;
        @(posedge clk); #1;
        key_load = 1'b0;
        key_in   = 16'($urandom);
        m_key    = k;
        model_clear();
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        force_rdy  = 1'b1;
        rdy_val    = 1'b1;
        rst        = 1'b1;
        key_load   = 1'b0;
        key_in     = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_decrypt = 1'b0;
        m_key      = 16'h0000;
        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        send_exp(8'h00, 1'b0, 8'h00);
        wait_drain("drain_t1");

        // Known-answer encrypt and latency
        load_key(16'h00A5);
        rdy_val = 1'b0;
        @(posedge clk); #1;
        send_exp(8'hFF, 1'b0, 8'hF5);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd5);

        // Hold in DONE under backpressure; key_load there must be ignored
        for (int i = 0; i < 10; i++) begin
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_data",  32'(out_data),  32'hF5);
            check("hold_in_ready",  32'(in_ready),  32'd0);
            key_load = (i == 0);
            key_in   = 16'h1234;
            @(posedge clk); #1;
        end
        key_load = 1'b0;
        rdy_val  = 1'b1;
        wait_drain("drain_t2");
        send_model(8'h3C, 1'b0);

        // key_load during RUN must also be ignored
        send_model(8'hC3, 1'b1);
        key_load = 1'b1;
        key_in   = 16'hBEEF;
        @(posedge clk); #1;
        key_load = 1'b0;
        wait_drain("drain_keyign");
        send_model(8'h5A, 1'b0);
        wait_drain("drain_keyign2");

        // Decrypt known answer and pure rotate with zero key
        load_key(16'h00A5);
        send_exp(8'hF5, 1'b1, 8'hFF);
        load_key(16'h0000);
        send_exp(8'h12, 1'b0, 8'h21);
        wait_drain("drain_t3");

        // key_load together with in_valid in IDLE: key taken, word refused
        key_load   = 1'b1;
        key_in     = 16'h5A3C;
        in_valid   = 1'b1;
        in_data    = 8'h99;
        in_decrypt = 1'b0;
        #1;
        check("kl_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        key_load = 1'b0;
        in_valid = 1'b0;
        check("kl_not_accepted", 32'(busy), 32'd0);
        m_key = 16'h5A3C;
        model_clear();
        send_model(8'h77, 1'b0);
        wait_drain("drain_t4");

        // Reset in the middle of RUN
        load_key(16'hA55A);
        send(8'h44, 1'b0, 8'h00, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data",  32'(out_data),  32'd0);
        exp_q.delete();
        m_key = 16'h0000;
        model_clear();
        send_exp(8'h12, 1'b0, 8'h21);
        wait_drain("drain_t5");

`ifdef OPT_CIPHER_CHAIN_EN
        // Chained stream and its inverse after key reload
        load_key(16'h00A5);
        send_exp(8'hFF, 1'b0, 8'hF5);
        y2 = model_step(8'hFF, 1'b0);
        send(8'hFF, 1'b0, y2, 1'b1);
        load_key(16'h00A5);
        send_exp(8'hF5, 1'b1, 8'hFF);
        send_exp(y2, 1'b1, 8'hFF);
        wait_drain("drain_t6");
`endif

        // Random words, random mode/key/backpressure
        force_rdy = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) load_key(16'($urandom));
            send_model(8'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
`ifndef OPT_CIPHER_CHAIN_EN
        // ECB round trip: decrypt of the ciphertext must give the plaintext
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0) load_key(16'($urandom));
            rx = 8'($urandom);
            ry = model_step(rx, 1'b0);
            send(rx, 1'b0, ry, 1'b1);
            send(ry, 1'b1, rx, 1'b1);
        end
`else
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) load_key(16'($urandom));
            send_model(8'($urandom), 1'($urandom_range(0, 1)));
        end
`endif
        wait_drain("drain_random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
